spike_rate_encoder: RTL

Upstream stage of the LIF network. Converts one N_CH-channel vector of DATA_W-bit intensities into parallel spike trains over a fixed window of WINDOW cycles. Each channel uses a phase accumulator. spike_out drives the network's per-neuron current inputs directly. A single-entry shadow register lets the next vector be queued while the current window runs.

---
 rtl/spike_rate_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spike_rate_encoder.sv
// Rate encoder: one phase accumulator per channel turns an intensity vector into spike trains over a fixed window.
// Optional SPIKE_ENC_DITHER_EN seeds each channel's accumulator from a shared 8-bit LFSR at window load.
module spike_rate_encoder #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int WINDOW = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   halt,
    output logic [N_CH-1:0]        spike_out,
    output logic                   busy,
    output logic                   window_done
);
    localparam int               CNT_W    = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                      r_state;
    logic [N_CH*DATA_W-1:0]      r_shadow;
    logic                        r_shadow_full;
    logic [N_CH-1:0][DATA_W-1:0] r_int;
    logic [N_CH-1:0][DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]            r_count;
    logic [N_CH-1:0]             r_spike;
    logic                        r_done;

    logic                        w_accept;
    logic [N_CH-1:0][DATA_W:0]   w_sum;
    logic [N_CH-1:0][DATA_W-1:0] w_acc_init;

    assign in_ready    = !r_shadow_full && !halt;
    assign w_accept    = in_valid && in_ready;
    assign spike_out   = r_spike;
    assign busy        = (r_state == S_RUN);
    assign window_done = r_done;

    // The carry out of each accumulator is that channel's spike.
    always_comb begin
        for (int k = 0; k < N_CH; k++)
            w_sum[k] = {1'b0, r_acc[k]} + {1'b0, r_int[k]};
    end

`ifdef SPIKE_ENC_DITHER_EN
    logic [7:0] r_lfsr;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] d;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_lfsr <= 8'h01;
        else if (r_state == S_RUN)
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    end

    // Each channel sees a different rotation so the trains start out of phase.
    always_comb begin
        for (int k = 0; k < N_CH; k++)
            w_acc_init[k] = DATA_W'(rotl8(r_lfsr, k % 8));
    end
`else
    assign w_acc_init = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_int         <= '0;
            r_acc         <= '0;
            r_count       <= '0;
            r_spike       <= '0;
            r_done        <= 1'b0;
        end else if (halt) begin
            r_state       <= S_IDLE;
            r_shadow_full <= 1'b0;
            r_count       <= '0;
            r_spike       <= '0;
            r_done        <= 1'b0;
        end else begin
            if (w_accept)
                r_shadow <= in_data;
            case (r_state)
                S_IDLE: begin
                    r_spike       <= '0;
                    r_done        <= 1'b0;
                    r_shadow_full <= w_accept;
                    if (r_shadow_full) begin
                        r_state <= S_RUN;
                        r_count <= '0;
                        for (int k = 0; k < N_CH; k++) begin
                            r_int[k] <= r_shadow[k*DATA_W +: DATA_W];
                            r_acc[k] <= w_acc_init[k];
                        end
                    end
                end
                S_RUN: begin
                    r_shadow_full <= r_shadow_full || w_accept;
                    for (int k = 0; k < N_CH; k++) begin
                        r_acc[k]   <= w_sum[k][DATA_W-1:0];
                        r_spike[k] <= w_sum[k][DATA_W];
                    end
                    // The last update of the window raises window_done alongside its spikes.
                    if (r_count == LAST_CNT) begin
                        r_done  <= 1'b1;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b0;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
